// File: rtl/ibex_rf_wb_sequencer.sv
// Register-file write-port sequencer: LSU writes take priority, EX writes
// queue in a small in-order buffer that is forwarded to both read ports.
module ibex_rf_wb_sequencer #(
  parameter bit          RV32E     = 1'b0,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned FifoDepth = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 ex_valid_i,
  output logic                 ex_ready_o,
  input  logic [4:0]           ex_waddr_i,
  input  logic [DataWidth-1:0] ex_wdata_i,
  input  logic                 lsu_valid_i,
  input  logic [4:0]           lsu_waddr_i,
  input  logic [DataWidth-1:0] lsu_wdata_i,
  output logic                 rf_we_o,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  input  logic [4:0]           raddr_a_i,
  input  logic [4:0]           raddr_b_i,
  output logic                 fwd_a_valid_o,
  output logic [DataWidth-1:0] fwd_a_data_o,
  output logic                 fwd_b_valid_o,
  output logic [DataWidth-1:0] fwd_b_data_o,
  output logic                 empty_o
);

  localparam int unsigned PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int unsigned CntW = $clog2(FifoDepth + 1);

  logic [FifoDepth-1:0] valid_q;
  logic [4:0]           waddr_q [FifoDepth];
  logic [DataWidth-1:0] wdata_q [FifoDepth];
  logic [PtrW-1:0]      head_q;
  logic [PtrW-1:0]      tail_q;
  logic [CntW-1:0]      count_q;

  logic full;
  logic ex_drop;
  logic ex_accept;
  logic push;
  logic lsu_we;
  logic pop;
  logic head_valid;

  assign full       = (count_q == CntW'(FifoDepth));
  assign ex_drop    = (ex_waddr_i == 5'd0) || (RV32E && ex_waddr_i[4]);
  assign ex_accept  = ex_valid_i && ex_ready_o;
  assign push       = ex_accept && !ex_drop && !flush_i;
  assign lsu_we     = lsu_valid_i && (lsu_waddr_i != 5'd0);
  assign pop        = !lsu_we && (count_q != '0);
  assign head_valid = valid_q[head_q];

  assign ex_ready_o = !rst_i && !full;
  assign empty_o    = rst_i || (count_q == '0);

  always_comb begin
    rf_we_o    = 1'b0;
    rf_waddr_o = '0;
    rf_wdata_o = '0;
    if (!rst_i) begin
      if (lsu_we) begin
        rf_we_o    = 1'b1;
        rf_waddr_o = lsu_waddr_i;
        rf_wdata_o = lsu_wdata_i;
      end else if (pop && head_valid) begin
        rf_we_o    = 1'b1;
        rf_waddr_o = waddr_q[head_q];
        rf_wdata_o = wdata_q[head_q];
      end
    end
  end

  // Walk oldest to youngest so the last match seen is the youngest.
  always_comb begin
    logic [PtrW-1:0] idx;
    idx           = '0;
    fwd_a_valid_o = 1'b0;
    fwd_a_data_o  = '0;
    fwd_b_valid_o = 1'b0;
    fwd_b_data_o  = '0;
    if (!rst_i) begin
      for (int i = 0; i < FifoDepth; i++) begin
        idx = head_q + PtrW'(i);
        if ((CntW'(i) < count_q) && valid_q[idx]) begin
          if ((waddr_q[idx] == raddr_a_i) && (raddr_a_i != 5'd0)) begin
            fwd_a_valid_o = 1'b1;
            fwd_a_data_o  = wdata_q[idx];
          end
          if ((waddr_q[idx] == raddr_b_i) && (raddr_b_i != 5'd0)) begin
            fwd_b_valid_o = 1'b1;
            fwd_b_data_o  = wdata_q[idx];
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      // An LSU write is younger than anything buffered: squash older matches.
      for (int i = 0; i < FifoDepth; i++) begin
        if (lsu_we && (waddr_q[i] == lsu_waddr_i)) begin
          valid_q[i] <= 1'b0;
        end
      end
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PtrW'(1);
      end
      if (push) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + PtrW'(1);
      end
      count_q <= count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && push) begin
      waddr_q[tail_q] <= ex_waddr_i;
      wdata_q[tail_q] <= ex_wdata_i;
    end
  end

endmodule

// File: tb/tb_ibex_rf_wb_sequencer.sv
// Directed testbench for ibex_rf_wb_sequencer (RV32E=1, depth 2).
module tb_ibex_rf_wb_sequencer;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        ex_valid;
  logic        ex_ready;
  logic [4:0]  ex_waddr;
  logic [31:0] ex_wdata;
  logic        lsu_valid;
  logic [4:0]  lsu_waddr;
  logic [31:0] lsu_wdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  raddr_a;
  logic [4:0]  raddr_b;
  logic        fwd_a_valid;
  logic [31:0] fwd_a_data;
  logic        fwd_b_valid;
  logic [31:0] fwd_b_data;
  logic        empty;

  int errors = 0;
  int checks = 0;

  ibex_rf_wb_sequencer #(
    .RV32E(1'b1),
    .DataWidth(32),
    .FifoDepth(2)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .flush_i(flush),
    .ex_valid_i(ex_valid),
    .ex_ready_o(ex_ready),
    .ex_waddr_i(ex_waddr),
    .ex_wdata_i(ex_wdata),
    .lsu_valid_i(lsu_valid),
    .lsu_waddr_i(lsu_waddr),
    .lsu_wdata_i(lsu_wdata),
    .rf_we_o(rf_we),
    .rf_waddr_o(rf_waddr),
    .rf_wdata_o(rf_wdata),
    .raddr_a_i(raddr_a),
    .raddr_b_i(raddr_b),
    .fwd_a_valid_o(fwd_a_valid),
    .fwd_a_data_o(fwd_a_data),
    .fwd_b_valid_o(fwd_b_valid),
    .fwd_b_data_o(fwd_b_data),
    .empty_o(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush     = 1'b0;
    ex_valid  = 1'b0;
    ex_waddr  = 5'd0;
    ex_wdata  = 32'd0;
    lsu_valid = 1'b0;
    lsu_waddr = 5'd0;
    lsu_wdata = 32'd0;
    raddr_a   = 5'd0;
    raddr_b   = 5'd0;
  endtask

  task automatic ex(input logic [4:0] a, input logic [31:0] d);
    ex_valid = 1'b1;
    ex_waddr = a;
    ex_wdata = d;
  endtask

  task automatic lsu(input logic [4:0] a, input logic [31:0] d);
    lsu_valid = 1'b1;
    lsu_waddr = a;
    lsu_wdata = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    ex(5'd3, 32'h1);
    lsu(5'd3, 32'h2);
    raddr_a = 5'd3;
    #2;
    checks++; if (ex_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %0h want 0", ex_ready); end
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %0h want 0", rf_we); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %0h want 1", empty); end
    checks++; if (fwd_a_valid !== 1'b0) begin errors++; $display("FAIL reset_fwd: got %0h want 0", fwd_a_valid); end
    tick();
    tick();
    idle();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    idle();
    ex(5'd5, 32'hA5A5_0001);
    #2;
    checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %0h want 1", ex_ready); end
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL single_we0: got %0h want 0", rf_we); end
    tick();
    idle();
    #2;
    checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL single_we1: got %0h want 1", rf_we); end
    checks++; if (rf_waddr !== 5'd5) begin errors++; $display("FAIL single_addr: got %0h want 5", rf_waddr); end
    checks++; if (rf_wdata !== 32'hA5A5_0001) begin errors++; $display("FAIL single_data: got %0h want a5a50001", rf_wdata); end
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL single_busy: got %0h want 0", empty); end
    tick();
    #2;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_empty: got %0h want 1", empty); end
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL single_we2: got %0h want 0", rf_we); end
    tick();
  endtask

  task automatic test_back_to_back();
    idle();
    lsu(5'd1, 32'h111);
    ex(5'd10, 32'hA);
    #2;
    checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready0: got %0h want 1", ex_ready); end
    checks++; if (rf_waddr !== 5'd1 || rf_wdata !== 32'h111) begin errors++; $display("FAIL b2b_lsu: got %0h/%0h want 1/111", rf_waddr, rf_wdata); end
    tick();
    ex(5'd11, 32'hB);
    #2;
    checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready1: got %0h want 1", ex_ready); end
    tick();
    ex(5'd12, 32'hC);
    #2;
    checks++; if (ex_ready !== 1'b0) begin errors++; $display("FAIL b2b_full: got %0h want 0", ex_ready); end
    tick();
    idle();
    #2;
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd10 || rf_wdata !== 32'hA) begin errors++; $display("FAIL b2b_drain0: got %0h/%0h/%0h want 1/a/a", rf_we, rf_waddr, rf_wdata); end
    tick();
    #2;
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd11 || rf_wdata !== 32'hB) begin errors++; $display("FAIL b2b_drain1: got %0h/%0h/%0h want 1/b/b", rf_we, rf_waddr, rf_wdata); end
    tick();
    #2;
    checks++; if (empty !== 1'b1 || rf_we !== 1'b0) begin errors++; $display("FAIL b2b_end: got %0h/%0h want 1/0", empty, rf_we); end
    tick();
  endtask

  task automatic test_squash();
    idle();
    ex(5'd7, 32'h1);
    tick();
    idle();
    lsu(5'd7, 32'h2);
    raddr_a = 5'd7;
    #2;
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'h2) begin errors++; $display("FAIL squash_lsu: got %0h/%0h/%0h want 1/7/2", rf_we, rf_waddr, rf_wdata); end
    checks++; if (fwd_a_valid !== 1'b1 || fwd_a_data !== 32'h1) begin errors++; $display("FAIL squash_prefwd: got %0h/%0h want 1/1", fwd_a_valid, fwd_a_data); end
    tick();
    lsu_valid = 1'b0;
    #2;
    checks++; if (fwd_a_valid !== 1'b0) begin errors++; $display("FAIL squash_fwd: got %0h want 0", fwd_a_valid); end
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL squash_we: got %0h want 0", rf_we); end
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL squash_count: got %0h want 0", empty); end
    tick();
    #2;
    checks++; if (empty !== 1'b1 || rf_we !== 1'b0) begin errors++; $display("FAIL squash_end: got %0h/%0h want 1/0", empty, rf_we); end
    tick();
  endtask

  task automatic test_same_cycle();
    idle();
    ex(5'd7, 32'h77);
    lsu(5'd7, 32'h70);
    #2;
    checks++; if (rf_we !== 1'b1 || rf_wdata !== 32'h70) begin errors++; $display("FAIL same_lsu: got %0h/%0h want 1/70", rf_we, rf_wdata); end
    tick();
    idle();
    #2;
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'h77) begin errors++; $display("FAIL same_ex: got %0h/%0h/%0h want 1/7/77", rf_we, rf_waddr, rf_wdata); end
    tick();
  endtask

  task automatic test_forward();
    idle();
    lsu(5'd1, 32'h5);
    ex(5'd3, 32'h10);
    tick();
    ex(5'd3, 32'h20);
    tick();
    ex_valid = 1'b0;
    raddr_a  = 5'd4;
    raddr_b  = 5'd3;
    #2;
    checks++; if (fwd_b_valid !== 1'b1 || fwd_b_data !== 32'h20) begin errors++; $display("FAIL fwd_young: got %0h/%0h want 1/20", fwd_b_valid, fwd_b_data); end
    checks++; if (fwd_a_valid !== 1'b0 || fwd_a_data !== 32'h0) begin errors++; $display("FAIL fwd_nomatch: got %0h/%0h want 0/0", fwd_a_valid, fwd_a_data); end
    tick();
    lsu_valid = 1'b0;
    #2;
    checks++; if (rf_we !== 1'b1 || rf_wdata !== 32'h10) begin errors++; $display("FAIL fwd_drain0: got %0h/%0h want 1/10", rf_we, rf_wdata); end
    checks++; if (fwd_b_data !== 32'h20) begin errors++; $display("FAIL fwd_hold: got %0h want 20", fwd_b_data); end
    tick();
    #2;
    checks++; if (rf_we !== 1'b1 || rf_wdata !== 32'h20) begin errors++; $display("FAIL fwd_drain1: got %0h/%0h want 1/20", rf_we, rf_wdata); end
    tick();
    #2;
    checks++; if (fwd_b_valid !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL fwd_end: got %0h/%0h want 0/1", fwd_b_valid, empty); end
    tick();
  endtask

  task automatic test_drop();
    idle();
    ex(5'd0, 32'hDEAD);
    #2;
    checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL drop_x0_ready: got %0h want 1", ex_ready); end
    tick();
    ex(5'd20, 32'hBEEF);
    #2;
    checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL drop_x20_ready: got %0h want 1", ex_ready); end
    checks++; if (rf_we !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL drop_x0_store: got %0h/%0h want 0/1", rf_we, empty); end
    tick();
    idle();
    lsu(5'd0, 32'h55);
    #2;
    checks++; if (rf_we !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL drop_lsu_x0: got %0h/%0h want 0/1", rf_we, empty); end
    tick();
    idle();
    #2;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL drop_end: got %0h want 0", rf_we); end
    tick();
  endtask

  task automatic test_flush();
    idle();
    lsu(5'd1, 32'h1);
    ex(5'd4, 32'h44);
    tick();
    ex(5'd6, 32'h66);
    tick();
    ex(5'd8, 32'h88);
    lsu(5'd9, 32'h99);
    flush = 1'b1;
    #2;
    checks++; if (ex_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %0h want 0", ex_ready); end
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 32'h99) begin errors++; $display("FAIL flush_lsu: got %0h/%0h/%0h want 1/9/99", rf_we, rf_waddr, rf_wdata); end
    tick();
    idle();
    #2;
    checks++; if (empty !== 1'b1 || rf_we !== 1'b0) begin errors++; $display("FAIL flush_empty: got %0h/%0h want 1/0", empty, rf_we); end
    ex(5'd8, 32'h88);
    flush = 1'b1;
    #1;
    checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL flush_ready2: got %0h want 1", ex_ready); end
    tick();
    idle();
    #2;
    checks++; if (empty !== 1'b1 || rf_we !== 1'b0) begin errors++; $display("FAIL flush_drop_ex: got %0h/%0h want 1/0", empty, rf_we); end
    tick();
  endtask

  task automatic test_reset_mid_drain();
    idle();
    lsu(5'd1, 32'h1);
    ex(5'd13, 32'hD);
    tick();
    idle();
    rst = 1'b1;
    #2;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL rst_drain_we: got %0h want 0", rf_we); end
    tick();
    rst = 1'b0;
    tick();
    #2;
    checks++; if (empty !== 1'b1 || rf_we !== 1'b0) begin errors++; $display("FAIL rst_drain_end: got %0h/%0h want 1/0", empty, rf_we); end
    tick();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_squash();
    test_same_cycle();
    test_forward();
    test_drop();
    test_flush();
    test_reset_mid_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
